// File: rtl/cpu_types_pkg.sv
// Shared CPU control types.
//   pctrl_state_t : pipeline controller FSM state encoding (RUN, DWAIT, HALTED)
//   STALL_MAX     : saturation value of the stall cycle counter
//   sat_inc32     : saturating 32-bit increment used by the stall counter
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pctrl_state_t;

    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == STALL_MAX) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector.
//   idex_dREN : ID/EX latch holds a load
//   idex_rt   : destination register of that load
//   ifid_rs/ifid_rt : source registers of the instruction in IF/ID
//   load_use  : IF/ID instruction needs the loaded value before it exists
module hazard_detect (
    input  logic       idex_dREN,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       load_use
);

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = idex_dREN & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: data-access wait FSM, hazard/branch/jump
// latch steering, sticky halt and a saturating stall counter.
//   CLK, nRST              : clock (rising edge), asynchronous active-low reset
//   ihit, dhit             : fetch / data access complete this cycle
//   exmem_dREN/dWEN/halt   : EX/MEM latch holds a load / store / HALT
//   branch_taken, jump     : control transfer resolved in MEM / decoded in ID
//   idex_dREN, idex_rt, ifid_rs, ifid_rt : load-use hazard inputs
//   pc_en, *_en, *_flush   : PC and pipeline latch controls (combinational)
//   halt, stall_count, state : registered status outputs
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dREN,
    input  logic        exmem_dWEN,
    input  logic        exmem_halt,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        idex_dREN,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        memwb_en,
    output logic        memwb_flush,
    output logic        halt,
    output logic [31:0] stall_count,
    output logic [1:0]  state
);

    pctrl_state_t state_r;
    logic         halt_r;
    logic [31:0]  stall_cnt_r;
    logic         pending_s;
    logic         load_use_s;

    assign pending_s   = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign state       = state_r;
    assign halt        = halt_r;
    assign stall_count = stall_cnt_r;

    hazard_detect u_hazard (
        .idex_dREN (idex_dREN),
        .idex_rt   (idex_rt),
        .ifid_rs   (ifid_rs),
        .ifid_rt   (ifid_rt),
        .load_use  (load_use_s)
    );

    // Latch steering: pending data access > branch > load-use > jump > fetch miss > normal.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        if (state_r == HALTED) begin
            pc_en = 1'b0;
        end else if (pending_s) begin
            // Freeze the front of the pipe and drop a bubble into MEM/WB.
            memwb_flush = 1'b1;
        end else begin
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (branch_taken) begin
                // Wrong-path instructions in IF/ID, ID/EX and EX/MEM are squashed;
                // exmem_en drops because flush must win on the same latch.
                pc_en       = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                exmem_en    = 1'b0;
            end else if (load_use_s) begin
                idex_flush = 1'b1;
            end else if (jump) begin
                pc_en      = ihit;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
            end else if (!ihit) begin
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                idex_en = 1'b1;
            end
        end
    end

    // Controller FSM with sticky halt flag; only reset leaves HALTED.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= RUN;
            halt_r  <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (pending_s) begin
                        state_r <= DWAIT;
                    end else if (exmem_halt) begin
                        state_r <= HALTED;
                        halt_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DWAIT: begin
                    if (pending_s) begin
                        state_r <= DWAIT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                HALTED: begin
                    state_r <= HALTED;
                    halt_r  <= 1'b1;
                end
                default: begin
                    state_r <= RUN;
                    halt_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stall counter: counts non-halted cycles where the PC does not advance.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= 32'd0;
        end else if ((state_r != HALTED) && !pc_en) begin
            stall_cnt_r <= sat_inc32(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl with a scoreboard queue and a
// negedge monitor that compares control outputs, state, stall count and halt.
module tb_pipeline_ctrl;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt;
    logic        branch_taken, jump, idex_dREN;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_flush;
    logic        halt;
    logic [31:0] stall_count;
    logic [1:0]  state;

    pipeline_ctrl dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .exmem_dREN   (exmem_dREN),
        .exmem_dWEN   (exmem_dWEN),
        .exmem_halt   (exmem_halt),
        .branch_taken (branch_taken),
        .jump         (jump),
        .idex_dREN    (idex_dREN),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .exmem_flush  (exmem_flush),
        .memwb_en     (memwb_en),
        .memwb_flush  (memwb_flush),
        .halt         (halt),
        .stall_count  (stall_count),
        .state        (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control vector order: {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
    localparam logic [8:0] C_NORM   = 9'b110101010;
    localparam logic [8:0] C_BUBBLE = 9'b000000001;
    localparam logic [8:0] C_LU     = 9'b000011010;
    localparam logic [8:0] C_BR     = 9'b101010110;
    localparam logic [8:0] C_JMP    = 9'b101101010;
    localparam logic [8:0] C_NOIHIT = 9'b001101010;
    localparam logic [8:0] C_OFF    = 9'b000000000;

    // Input vector order: {ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, branch_taken, jump, idex_dREN}
    localparam logic [7:0] I_IDLE  = 8'b1000_0000;
    localparam logic [7:0] I_MISS  = 8'b0000_0000;
    localparam logic [7:0] I_LDP   = 8'b1010_0000;
    localparam logic [7:0] I_LDH   = 8'b1110_0000;
    localparam logic [7:0] I_STP   = 8'b1001_0000;
    localparam logic [7:0] I_STH   = 8'b1101_0000;
    localparam logic [7:0] I_LU    = 8'b1000_0001;
    localparam logic [7:0] I_JMP   = 8'b1000_0010;
    localparam logic [7:0] I_JMPM  = 8'b0000_0010;
    localparam logic [7:0] I_BRALL = 8'b0000_0111;
    localparam logic [7:0] I_LDPBR = 8'b1010_0100;
    localparam logic [7:0] I_HALT  = 8'b1000_1000;
    localparam logic [7:0] I_LUM   = 8'b0000_0001;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_DW  = 2'd1;
    localparam logic [1:0] S_HLT = 2'd2;

    typedef struct {
        string       nm;
        logic [8:0]  ctl;
        logic [1:0]  st;
        logic [31:0] sc;
        logic        hl;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [8:0] got_ctl;
    int total = 0;
    int bad   = 0;

    // Called at posedge+1: apply one cycle of inputs, queue the expectation, advance.
    task automatic cyc(input string nm, input logic rst, input logic [7:0] in,
                       input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2,
                       input logic [8:0] ctl, input logic [1:0] st,
                       input logic [31:0] sc, input logic hl);
        exp_t e;
        nRST = rst;
        {ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, branch_taken, jump, idex_dREN} = in;
        idex_rt = rt;
        ifid_rs = rs;
        ifid_rt = rt2;
        e.nm  = nm;
        e.ctl = ctl;
        e.st  = st;
        e.sc  = sc;
        e.hl  = hl;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every negedge, compare DUT outputs against the oldest expectation.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            got_ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                       exmem_en, exmem_flush, memwb_en, memwb_flush};
            total++;
            if (got_ctl !== mon_e.ctl) begin
                bad++;
                $display("FAIL %s ctl: got=%b exp=%b", mon_e.nm, got_ctl, mon_e.ctl);
            end
            total++;
            if (state !== mon_e.st) begin
                bad++;
                $display("FAIL %s state: got=%0d exp=%0d", mon_e.nm, state, mon_e.st);
            end
            total++;
            if (stall_count !== mon_e.sc) begin
                bad++;
                $display("FAIL %s stall_count: got=%h exp=%h", mon_e.nm, stall_count, mon_e.sc);
            end
            total++;
            if (halt !== mon_e.hl) begin
                bad++;
                $display("FAIL %s halt: got=%b exp=%b", mon_e.nm, halt, mon_e.hl);
            end
        end
    end

    initial begin
        nRST = 1'b1;
        {ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, branch_taken, jump, idex_dREN} = 8'd0;
        idex_rt = 5'd0;
        ifid_rs = 5'd0;
        ifid_rt = 5'd0;
        #1 nRST = 1'b0;
        @(posedge CLK);
        #1;
        cyc("reset",       1'b0, I_IDLE,  5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'd0, 1'b0);
        cyc("idle",        1'b1, I_IDLE,  5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'd0, 1'b0);
        cyc("imiss",       1'b1, I_MISS,  5'd0, 5'd0, 5'd0, C_NOIHIT, S_RUN, 32'd0, 1'b0);
        cyc("idle2",       1'b1, I_IDLE,  5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'd1, 1'b0);
        cyc("lu_rs",       1'b1, I_LU,    5'd5, 5'd5, 5'd1, C_LU,     S_RUN, 32'd1, 1'b0);
        cyc("lu_r0",       1'b1, I_LU,    5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'd2, 1'b0);
        cyc("lu_rt",       1'b1, I_LU,    5'd7, 5'd3, 5'd7, C_LU,     S_RUN, 32'd2, 1'b0);
        cyc("lu_nomatch",  1'b1, I_LU,    5'd7, 5'd3, 5'd4, C_NORM,   S_RUN, 32'd3, 1'b0);
        cyc("jump",        1'b1, I_JMP,   5'd0, 5'd0, 5'd0, C_JMP,    S_RUN, 32'd3, 1'b0);
        cyc("jump_miss",   1'b1, I_JMPM,  5'd0, 5'd0, 5'd0, C_NOIHIT, S_RUN, 32'd3, 1'b0);
        cyc("br_override", 1'b1, I_BRALL, 5'd5, 5'd5, 5'd0, C_BR,     S_RUN, 32'd4, 1'b0);
        cyc("ld_wait1",    1'b1, I_LDP,   5'd0, 5'd0, 5'd0, C_BUBBLE, S_RUN, 32'd4, 1'b0);
        cyc("ld_wait2",    1'b1, I_LDP,   5'd0, 5'd0, 5'd0, C_BUBBLE, S_DW,  32'd5, 1'b0);
        cyc("ld_wait3",    1'b1, I_LDP,   5'd0, 5'd0, 5'd0, C_BUBBLE, S_DW,  32'd6, 1'b0);
        cyc("ld_dhit",     1'b1, I_LDH,   5'd0, 5'd0, 5'd0, C_NORM,   S_DW,  32'd7, 1'b0);
        cyc("after_ld",    1'b1, I_IDLE,  5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'd7, 1'b0);
        cyc("st_wait",     1'b1, I_STP,   5'd0, 5'd0, 5'd0, C_BUBBLE, S_RUN, 32'd7, 1'b0);
        cyc("st_dhit",     1'b1, I_STH,   5'd0, 5'd0, 5'd0, C_NORM,   S_DW,  32'd8, 1'b0);
        cyc("pend_over_br",1'b1, I_LDPBR, 5'd0, 5'd0, 5'd0, C_BUBBLE, S_RUN, 32'd8, 1'b0);
        cyc("dwait_again", 1'b1, I_LDP,   5'd0, 5'd0, 5'd0, C_BUBBLE, S_DW,  32'd9, 1'b0);
        // nRST dropped between edges while in DWAIT: effect must be immediate.
        cyc("rst_dwait",   1'b0, I_LDP,   5'd0, 5'd0, 5'd0, C_BUBBLE, S_RUN, 32'd0, 1'b0);
        cyc("post_rst",    1'b1, I_IDLE,  5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'd0, 1'b0);
        cyc("miss_pre_h",  1'b1, I_MISS,  5'd0, 5'd0, 5'd0, C_NOIHIT, S_RUN, 32'd0, 1'b0);
        cyc("halt_in",     1'b1, I_HALT,  5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc("halted",  1'b1, I_LUM,   5'd5, 5'd5, 5'd0, C_OFF,    S_HLT, 32'd1, 1'b1);
        end
        cyc("rst_halt",    1'b0, I_IDLE,  5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'd0, 1'b0);
        cyc("post_rst2",   1'b1, I_IDLE,  5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'd0, 1'b0);
        force dut.stall_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_r;
        cyc("sat1",        1'b1, I_MISS,  5'd0, 5'd0, 5'd0, C_NOIHIT, S_RUN, 32'hFFFF_FFFE, 1'b0);
        cyc("sat2",        1'b1, I_MISS,  5'd0, 5'd0, 5'd0, C_NOIHIT, S_RUN, 32'hFFFF_FFFF, 1'b0);
        cyc("sat3",        1'b1, I_MISS,  5'd0, 5'd0, 5'd0, C_NOIHIT, S_RUN, 32'hFFFF_FFFF, 1'b0);
        cyc("sat_hold",    1'b1, I_IDLE,  5'd0, 5'd0, 5'd0, C_NORM,   S_RUN, 32'hFFFF_FFFF, 1'b0);
        // Bounded drain: the monitor must have consumed every expectation.
        repeat (3) @(negedge CLK);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending expectations exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
